// File: rtl/shift_reg_pipe.sv
// -----------------------------------------------------------------------------
// shift_reg_pipe
//   Enable-gated shift-register pipeline of DEPTH stages. Each stage holds a
//   WIDTH-bit data word plus a valid bit. A synchronous flush clears every
//   stage and has priority over the shift enable. count reports how many
//   stages currently hold a valid entry.
//
// Parameters
//   WIDTH      data bits per stage (1..64)
//   DEPTH      number of register stages (1..64)
//   RESET_VAL  value loaded into every data stage on reset and flush
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   D          data into stage 0
//   d_valid    qualifier captured alongside D
//   en         shift enable; low holds every stage
//   flush      synchronous clear of all stages (wins over en)
//   Q          data of the last stage (DEPTH-1)
//   q_valid    valid bit of the last stage
//   count      number of stages whose valid bit is set (0..DEPTH)
//
// Optional feature (macro SHIFT_REG_PIPE_TAP_OUT_EN)
//   taps       WIDTH*DEPTH bits, bits [WIDTH*(i+1)-1 : WIDTH*i] = data stage i
//   tap_valid  DEPTH bits, bit i = valid bit of stage i
// -----------------------------------------------------------------------------
module shift_reg_pipe #(
   parameter int unsigned            WIDTH     = 1,
   parameter int unsigned            DEPTH     = 4,
   parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             D,
   input  logic                         d_valid,
   input  logic                         en,
   input  logic                         flush,
   output logic [WIDTH-1:0]             Q,
   output logic                         q_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef SHIFT_REG_PIPE_TAP_OUT_EN
   ,
   output logic [WIDTH*DEPTH-1:0]       taps,
   output logic [DEPTH-1:0]             tap_valid
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;

   // NOTE: every stage is a plain register (not RAM), so each one is reset;
   // state is updated with non-blocking assignments so all stages sample the
   // previous-cycle value of their neighbour on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i]  <= RESET_VAL;
            valid_q[i] <= 1'b0;
         end
      end else if (flush) begin
         // Flush beats en; the word presented on this edge is discarded.
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i]  <= RESET_VAL;
            valid_q[i] <= 1'b0;
         end
      end else if (en) begin
         // Data is captured regardless of d_valid; only the valid bit
         // qualifies it, so an unknown D cannot disturb valid bits or count.
         data_q[0]  <= D;
         valid_q[0] <= d_valid;
         for (int i = 1; i < int'(DEPTH); i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
         end
      end
   end

   assign Q       = data_q[DEPTH-1];
   assign q_valid = valid_q[DEPTH-1];

   // NOTE: the accumulator is given a default before the loop so no latch
   // is inferred.
   always_comb begin
      count = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         count = count + CNT_W'(valid_q[i]);
      end
   end

`ifdef SHIFT_REG_PIPE_TAP_OUT_EN
   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_taps
      assign taps[WIDTH*g +: WIDTH] = data_q[g];
   end
   assign tap_valid = valid_q;
`endif

endmodule

// File: tb/tb_shift_reg_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_pipe
//   Self-checking bench for shift_reg_pipe. Main instance: WIDTH=8, DEPTH=4,
//   RESET_VAL=0. A second instance with WIDTH=1, DEPTH=1 is exercised as an
//   enabled D flip-flop. The reference model is a queue of entries: an
//   enabled edge pushes the new entry at the front and drops the oldest.
// -----------------------------------------------------------------------------
module tb_shift_reg_pipe;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] D = '0;
   logic         d_valid = 1'b0;
   logic         en = 1'b0;
   logic         flush = 1'b0;
   logic [W-1:0] Q;
   logic         q_valid;
   logic [2:0]   count;
`ifdef SHIFT_REG_PIPE_TAP_OUT_EN
   logic [W*N-1:0] taps;
   logic [N-1:0]   tap_valid;
`endif

   // degenerate instance signals
   logic d1 = 1'b0, dv1 = 1'b0, en1 = 1'b0, flush1 = 1'b0;
   logic q1, qv1;
   logic [0:0] count1;
`ifdef SHIFT_REG_PIPE_TAP_OUT_EN
   logic [0:0] taps1;
   logic [0:0] tap_valid1;
`endif

   always #5 clk = ~clk;

   shift_reg_pipe #(.WIDTH(W), .DEPTH(N), .RESET_VAL(8'h00)) u_dut (
      .clk(clk), .rst(rst), .D(D), .d_valid(d_valid), .en(en), .flush(flush),
      .Q(Q), .q_valid(q_valid), .count(count)
`ifdef SHIFT_REG_PIPE_TAP_OUT_EN
      , .taps(taps), .tap_valid(tap_valid)
`endif
   );

   shift_reg_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .D(d1), .d_valid(dv1), .en(en1), .flush(flush1),
      .Q(q1), .q_valid(qv1), .count(count1)
`ifdef SHIFT_REG_PIPE_TAP_OUT_EN
      , .taps(taps1), .tap_valid(tap_valid1)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model: index 0 is the newest entry, index N-1 drives Q
   logic [W-1:0] m_data[$];
   bit           m_valid[$];
   logic         m1;
   logic         m1_valid;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_data.delete();
      m_valid.delete();
      for (int i = 0; i < N; i++) begin
         m_data.push_back(8'h00);
         m_valid.push_back(1'b0);
      end
      m1       = 1'b0;
      m1_valid = 1'b0;
   endtask

   function automatic int model_count();
      int c = 0;
      foreach (m_valid[i]) if (m_valid[i]) c++;
      return c;
   endfunction

   // One clock: drive inputs away from the edge, advance the model on the
   // edge, then compare #1 later.
   task automatic step(input logic [W-1:0] d, input logic dv, input logic e, input logic f);
      logic b_d, b_dv, b_en;
      D = d; d_valid = dv; en = e; flush = f;
      b_d  = 1'($urandom);
      b_dv = 1'($urandom);
      b_en = 1'($urandom);
      d1 = b_d; dv1 = b_dv; en1 = b_en;
      @(posedge clk);
      if (f) begin
         for (int i = 0; i < N; i++) begin
            m_data[i]  = 8'h00;
            m_valid[i] = 1'b0;
         end
      end else if (e) begin
         m_data.push_front(d);
         m_valid.push_front(dv);
         void'(m_data.pop_back());
         void'(m_valid.pop_back());
      end
      if (b_en) begin
         m1       = b_d;
         m1_valid = b_dv;
      end
      #1;
      check("q",       Q,       m_data[N-1]);
      check("q_valid", q_valid, m_valid[N-1]);
      check("count",   count,   model_count());
      check("dff_q",   q1,      m1);
      check("dff_qv",  qv1,     m1_valid);
   endtask

   initial begin
      logic [W-1:0] seen[$];
      model_clear();

      // ---- reset state while rst low (before any release)
      #2;
      check("rst_q",     Q,       8'h00);
      check("rst_qv",    q_valid, 1'b0);
      check("rst_count", count,   3'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // ---- latency: single valid A5, then invalid words
      for (int k = 1; k <= 5; k++) begin
         if (k == 1) step(8'hA5, 1'b1, 1'b1, 1'b0);
         else        step(8'(k), 1'b0, 1'b1, 1'b0);
         check("lat_qv",    q_valid, (k == 4));
         check("lat_count", count,   (k <= 4) ? 3'd1 : 3'd0);
         if (k == 4) check("lat_q", Q, 8'hA5);
      end

      // ---- stall: 0x01..0x04, en low for two edges after the 2nd word
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'h01, 1'b1, 1'b1, 1'b0);
      step(8'h02, 1'b1, 1'b1, 1'b0);
      step(8'hEE, 1'b1, 1'b0, 1'b0);
      check("stall_count", count, 3'd2);
      step(8'hEE, 1'b1, 1'b0, 1'b0);
      check("stall_count", count, 3'd2);
      step(8'h03, 1'b1, 1'b1, 1'b0);
      step(8'h04, 1'b1, 1'b1, 1'b0);
      check("stall_full", count, 3'd4);
      // 0x01 reached the last stage on the 6th edge after its capture edge's
      // predecessor: 4 shifts plus 2 stalled edges
      if (q_valid) seen.push_back(Q);
      for (int k = 0; k < 3; k++) begin
         step(8'h00, 1'b0, 1'b1, 1'b0);
         if (q_valid) seen.push_back(Q);
      end
      check("stall_n", seen.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < seen.size()) check("stall_order", seen[k], 8'(k + 1));

      // ---- flush priority over en with a full pipe
      for (int k = 0; k < N; k++) step(8'(8'h10 + k), 1'b1, 1'b1, 1'b0);
      check("fl_full", count, 3'd4);
      step(8'h77, 1'b1, 1'b1, 1'b1);
      check("fl_count", count, 3'd0);
      check("fl_q",     Q,     8'h00);
      for (int k = 0; k < N + 1; k++) begin
         step(8'h00, 1'b0, 1'b1, 1'b0);
         check("fl_no77", (Q == 8'h77), 1'b0);
      end

      // ---- X on D with d_valid=0 must not disturb valid bits or count
      for (int k = 0; k < N; k++) begin
         D = 'x; d_valid = 1'b0; en = 1'b1; flush = 1'b0;
         @(posedge clk);
         m_data.push_front(8'h00);
         m_valid.push_front(1'b0);
         void'(m_data.pop_back());
         void'(m_valid.pop_back());
         #1;
         check("x_qv",    q_valid, 1'b0);
         check("x_count", count,   3'd0);
      end
      step(8'h00, 1'b0, 1'b0, 1'b1);

`ifdef SHIFT_REG_PIPE_TAP_OUT_EN
      // ---- taps
      step(8'h11, 1'b1, 1'b1, 1'b0);
      step(8'h22, 1'b1, 1'b1, 1'b0);
      step(8'h33, 1'b1, 1'b1, 1'b0);
      step(8'h44, 1'b1, 1'b1, 1'b0);
      check("taps",      taps,      32'h11223344);
      check("tap_valid", tap_valid, 4'b1111);
`endif

      // ---- randomized traffic
      for (int k = 0; k < 300; k++) begin
         step(8'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      end

      // ---- asynchronous reset mid-cycle with stages loaded
      for (int k = 0; k < N; k++) step(8'($urandom | 1), 1'b1, 1'b1, 1'b0);
      check("pre_rst_count", count, 3'd4);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_q",     Q,       8'h00);
      check("arst_qv",    q_valid, 1'b0);
      check("arst_count", count,   3'd0);
      check("arst_dff",   q1,      1'b0);
      model_clear();
      // held in reset across an edge with active inputs
      D = 8'hC3; d_valid = 1'b1; en = 1'b1; flush = 1'b0;
      @(posedge clk); #1;
      check("hold_rst_q",     Q,     8'h00);
      check("hold_rst_count", count, 3'd0);
      rst = 1'b1;

      // ---- more random traffic after reset release
      for (int k = 0; k < 100; k++) begin
         step(8'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_reg_pipe.md
SHIFT_REG_PIPE -- requirements
Module: shift_reg_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, data bits per stage (legal range 1 to 64).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of register stages (legal range 1 to 64).
REQ-003 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset and flush.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port D, input, WIDTH bits, data into stage 0.
REQ-007 The block SHALL have port d_valid, input, 1 bit, qualifier captured alongside D.
REQ-008 The block SHALL have port en, input, 1 bit, shift enable; low holds all stages.
REQ-009 The block SHALL have port flush, input, 1 bit, synchronous clear of all stages.
REQ-010 The block SHALL have port Q, output, WIDTH bits, data of the last stage (DEPTH-1).
REQ-011 The block SHALL have port q_valid, output, 1 bit, valid bit of the last stage.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+1) bits, number of stages whose valid bit is set.

Function
REQ-013 With flush high on a rising clk edge, all data stages SHALL load RESET_VAL and all valid bits SHALL clear, regardless of en.
REQ-014 With flush low and en high, stage 0 SHALL load {D, d_valid}, and each stage i from 1 to DEPTH-1 SHALL load stage i-1.
REQ-015 With flush low and en low, every data stage and valid bit SHALL hold its value.
REQ-016 When en is held high, D SHALL appear on Q exactly DEPTH rising edges after capture (for DEPTH=1: one edge, i.e. a plain enabled D flip-flop).
REQ-017 A stall (en low) SHALL add one cycle of latency per stalled edge without losing or duplicating any stage contents.
REQ-018 Invalid entries (d_valid=0) SHALL shift like valid entries; the data field SHALL be captured unconditionally.
REQ-019 count SHALL be the combinational popcount of the DEPTH valid bits, range 0 to DEPTH, and SHALL change only after clock edges or reset.
REQ-020 When flush and en are both high, flush SHALL win, and the D/d_valid presented on that edge SHALL be discarded.
REQ-021 An entry shifted out of the last stage while en is high SHALL be dropped; no backpressure exists.
REQ-022 X on D with d_valid=0 SHALL NOT corrupt any valid bit or count.

Reset
REQ-023 While rst is low, all data stages SHALL be RESET_VAL, all valid bits 0, Q=RESET_VAL, q_valid=0, count=0, independent of clk.
REQ-024 Deassertion of rst SHALL take effect at the first rising clk edge after rst goes high; an assertion mid-operation SHALL discard all in-flight entries immediately.

Configuration
REQ-025 When macro SHIFT_REG_PIPE_TAP_OUT_EN is defined, the block SHALL add output port taps, WIDTH*DEPTH bits, where bits [WIDTH*(i+1)-1 : WIDTH*i] equal data stage i, together with output tap_valid, DEPTH bits, where bit i is the valid bit of stage i.
REQ-026 When SHIFT_REG_PIPE_TAP_OUT_EN is undefined, the ports taps and tap_valid SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0 unless stated)
REQ-027 Reset: rst=0 asserted mid-clock with stages loaded -> Q=0x00, q_valid=0, count=0 immediately, without a clk edge.
REQ-028 Latency: en=1, D=0xA5 with d_valid=1 for one edge, then d_valid=0 -> Q=0xA5 and q_valid=1 on the 4th edge only; count goes 1,1,1,1,0.
REQ-029 Stall: stream 0x01..0x04 with en=1, drop en for 2 edges after the 2nd edge -> Q sequence 0x01..0x04 in order, arriving 2 cycles late; count holds during the stall.
REQ-030 Flush priority: pipe full (count=4), flush=1 and en=1 with D=0x77, d_valid=1 -> next edge count=0, Q=0x00, and 0x77 never appears on Q.
REQ-031 Degenerate: DEPTH=1, WIDTH=1 -> Q follows D one edge later when en=1 and holds when en=0, i.e. an enabled D flip-flop.
REQ-032 Taps: with SHIFT_REG_PIPE_TAP_OUT_EN defined, after loading 0x11,0x22,0x33,0x44 -> taps=0x11223344 (stage 3 is the MSB byte) and tap_valid=4'b1111.
